// File: rtl/alu_sequencer_if.sv
// Control bundle between the hardwired ALU sequencer and its datapath:
// run/IR into the sequencer, one-hot register enables and datapath strobes out.
interface alu_sequencer_if #(
   parameter int NREG = 16
);
   logic            run;
   logic [31:0]     ir;
   logic [NREG-1:0] Rin;
   logic [NREG-1:0] Rout;
   logic            PCout;
   logic            PCin;
   logic            MARin;
   logic            IncPC;
   logic            Read;
   logic            MDRin;
   logic            MDRout;
   logic            IRin;
   logic            Yin;
   logic            Zlowin;
   logic            Zhighin;
   logic            Zlowout;
   logic            Zhighout;
   logic            LOin;
   logic            HIin;
   logic [3:0]      ALUop;
   logic            ALU_MUL;
   logic            ALU_DIV;
   logic            halted;
   logic            illegal;
   logic [15:0]     retired;

   modport master (
      input  run, ir,
      output Rin, Rout, PCout, PCin, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
             Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
             ALUop, ALU_MUL, ALU_DIV, halted, illegal, retired
   );

   modport slave (
      output run, ir,
      input  Rin, Rout, PCout, PCin, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
             Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
             ALUop, ALU_MUL, ALU_DIV, halted, illegal, retired
   );
endinterface

// File: rtl/alu_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then execute (T3-T6) of register-register
// ALU instructions; strobes are a Moore function of the state and the IR.
module alu_sequencer #(
   parameter int         NREG    = 16,
   parameter logic [4:0] HALT_OP = 5'd31
) (
   input logic            clock,
   input logic            clear,
   alu_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      T5   = 4'd6,
      T6   = 4'd7,
      HALT = 4'd8
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic            illegal_r;
   logic [15:0]     retired_r;
   logic            retire_s;
   logic            set_illegal_s;

   logic [4:0]      op_s;
   logic            cls_alu_s;
   logic            cls_muldiv_s;
   logic            cls_unary_s;
   logic            cls_halt_s;
   logic            cls_bad_s;
   logic [NREG-1:0] ra_oh_s;
   logic [NREG-1:0] rb_oh_s;
   logic [NREG-1:0] rc_oh_s;
   logic [14:0]     ir_unused_s;

   logic [NREG-1:0] rin_s;
   logic [NREG-1:0] rout_s;
   logic            pcout_s, pcin_s, marin_s, incpc_s, read_s, mdrin_s, mdrout_s, irin_s, yin_s;
   logic            zlowin_s, zhighin_s, zlowout_s, zhighout_s, loin_s, hiin_s;
   logic [3:0]      aluop_s;
   logic            alu_mul_s;
   logic            alu_div_s;

   function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
      onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign ir_unused_s = bus.ir[14:0];

   // Opcode class decode; HALT_OP takes priority should it alias a defined opcode.
   always_comb begin
      op_s         = bus.ir[31:27];
      ra_oh_s      = onehot(bus.ir[26:23]);
      rb_oh_s      = onehot(bus.ir[22:19]);
      rc_oh_s      = onehot(bus.ir[18:15]);
      cls_halt_s   = (op_s == HALT_OP);
      cls_alu_s    = !cls_halt_s && (op_s <= 5'd8);
      cls_muldiv_s = !cls_halt_s && ((op_s == 5'd9) || (op_s == 5'd10));
      cls_unary_s  = !cls_halt_s && ((op_s == 5'd11) || (op_s == 5'd12));
      cls_bad_s    = !(cls_halt_s || cls_alu_s || cls_muldiv_s || cls_unary_s);
   end

   // Next-state logic; retire_s marks the edge leaving an instruction's last cycle.
   always_comb begin
      state_s       = state_r;
      retire_s      = 1'b0;
      set_illegal_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.run) state_s = T0;
            else         state_s = IDLE;
         end
         T0: state_s = T1;
         T1: state_s = T2;
         T2: state_s = T3;
         T3: begin
            if (cls_halt_s) begin
               retire_s = 1'b1;
               state_s  = HALT;
            end else if (cls_bad_s) begin
               set_illegal_s = 1'b1;
               state_s       = HALT;
            end else begin
               state_s = T4;
            end
         end
         T4: begin
            if (cls_unary_s) begin
               retire_s = 1'b1;
               state_s  = bus.run ? T0 : IDLE;
            end else begin
               state_s = T5;
            end
         end
         T5: begin
            if (cls_muldiv_s) begin
               state_s = T6;
            end else begin
               retire_s = 1'b1;
               state_s  = bus.run ? T0 : IDLE;
            end
         end
         T6: begin
            retire_s = 1'b1;
            state_s  = bus.run ? T0 : IDLE;
         end
         HALT:    state_s = HALT;
         default: state_s = IDLE;
      endcase
   end

   // State, sticky illegal flag and wrapping retired-instruction counter.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_r   <= IDLE;
         illegal_r <= 1'b0;
         retired_r <= 16'd0;
      end else begin
         state_r <= state_s;
         if (set_illegal_s) illegal_r <= 1'b1;
         if (retire_s)      retired_r <= retired_r + 16'd1;
      end
   end

   // Moore strobe decode: exactly one bus driver in any cycle, nothing in IDLE/HALT.
   always_comb begin
      rin_s      = {NREG{1'b0}};
      rout_s     = {NREG{1'b0}};
      pcout_s    = 1'b0;
      pcin_s     = 1'b0;
      marin_s    = 1'b0;
      incpc_s    = 1'b0;
      read_s     = 1'b0;
      mdrin_s    = 1'b0;
      mdrout_s   = 1'b0;
      irin_s     = 1'b0;
      yin_s      = 1'b0;
      zlowin_s   = 1'b0;
      zhighin_s  = 1'b0;
      zlowout_s  = 1'b0;
      zhighout_s = 1'b0;
      loin_s     = 1'b0;
      hiin_s     = 1'b0;
      aluop_s    = 4'd0;
      alu_mul_s  = 1'b0;
      alu_div_s  = 1'b0;
      case (state_r)
         T0: begin
            pcout_s  = 1'b1;
            marin_s  = 1'b1;
            incpc_s  = 1'b1;
            zlowin_s = 1'b1;
         end
         T1: begin
            zlowout_s = 1'b1;
            pcin_s    = 1'b1;
            read_s    = 1'b1;
            mdrin_s   = 1'b1;
         end
         T2: begin
            mdrout_s = 1'b1;
            irin_s   = 1'b1;
         end
         T3: begin
            if (cls_alu_s) begin
               rout_s = rb_oh_s;
               yin_s  = 1'b1;
            end else if (cls_muldiv_s) begin
               rout_s = ra_oh_s;
               yin_s  = 1'b1;
            end else if (cls_unary_s) begin
               rout_s   = rb_oh_s;
               aluop_s  = op_s[3:0];
               zlowin_s = 1'b1;
            end else begin
               rout_s = {NREG{1'b0}};
            end
         end
         T4: begin
            if (cls_alu_s) begin
               rout_s   = rc_oh_s;
               aluop_s  = op_s[3:0];
               zlowin_s = 1'b1;
            end else if (cls_muldiv_s) begin
               rout_s    = rb_oh_s;
               alu_mul_s = (op_s == 5'd9);
               alu_div_s = (op_s == 5'd10);
               zlowin_s  = 1'b1;
               zhighin_s = 1'b1;
            end else if (cls_unary_s) begin
               zlowout_s = 1'b1;
               rin_s     = ra_oh_s;
            end else begin
               rin_s = {NREG{1'b0}};
            end
         end
         T5: begin
            if (cls_alu_s) begin
               zlowout_s = 1'b1;
               rin_s     = ra_oh_s;
            end else if (cls_muldiv_s) begin
               zlowout_s = 1'b1;
               loin_s    = 1'b1;
            end else begin
               rin_s = {NREG{1'b0}};
            end
         end
         T6: begin
            if (cls_muldiv_s) begin
               zhighout_s = 1'b1;
               hiin_s     = 1'b1;
            end else begin
               hiin_s = 1'b0;
            end
         end
         default: rin_s = {NREG{1'b0}};
      endcase
   end

   assign bus.Rin      = rin_s;
   assign bus.Rout     = rout_s;
   assign bus.PCout    = pcout_s;
   assign bus.PCin     = pcin_s;
   assign bus.MARin    = marin_s;
   assign bus.IncPC    = incpc_s;
   assign bus.Read     = read_s;
   assign bus.MDRin    = mdrin_s;
   assign bus.MDRout   = mdrout_s;
   assign bus.IRin     = irin_s;
   assign bus.Yin      = yin_s;
   assign bus.Zlowin   = zlowin_s;
   assign bus.Zhighin  = zhighin_s;
   assign bus.Zlowout  = zlowout_s;
   assign bus.Zhighout = zhighout_s;
   assign bus.LOin     = loin_s;
   assign bus.HIin     = hiin_s;
   assign bus.ALUop    = aluop_s;
   assign bus.ALU_MUL  = alu_mul_s;
   assign bus.ALU_DIV  = alu_div_s;
   assign bus.halted   = (state_r == HALT);
   assign bus.illegal  = illegal_r;
   assign bus.retired  = retired_r;

endmodule
